// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: register map, TX CMD codes, reset values, RX events
// and the PHY-side FSM encoding. Used by both the PHY model and the link side.
package ulpi_pkg;

    localparam int ULPI_DATA_W = 8;

    localparam logic [1:0] CMD_REGW = 2'b10;
    localparam logic [1:0] CMD_REGR = 2'b11;

    localparam logic [5:0] REG_VID_LO     = 6'h00;
    localparam logic [5:0] REG_VID_HI     = 6'h01;
    localparam logic [5:0] REG_PID_LO     = 6'h02;
    localparam logic [5:0] REG_PID_HI     = 6'h03;
    localparam logic [5:0] REG_FUNC_CTRL  = 6'h04;
    localparam logic [5:0] REG_FUNC_SET   = 6'h05;
    localparam logic [5:0] REG_FUNC_CLR   = 6'h06;
    localparam logic [5:0] REG_INTF_CTRL  = 6'h07;
    localparam logic [5:0] REG_INTF_SET   = 6'h08;
    localparam logic [5:0] REG_INTF_CLR   = 6'h09;
    localparam logic [5:0] REG_OTG_CTRL   = 6'h0A;
    localparam logic [5:0] REG_OTG_SET    = 6'h0B;
    localparam logic [5:0] REG_OTG_CLR    = 6'h0C;
    localparam logic [5:0] REG_SCRATCH    = 6'h16;
    localparam logic [5:0] REG_SCRATCH_SET = 6'h17;
    localparam logic [5:0] REG_SCRATCH_CLR = 6'h18;

    localparam logic [7:0] FUNC_CTRL_RST = 8'h41;
    localparam logic [7:0] INTF_CTRL_RST = 8'h00;
    localparam logic [7:0] OTG_CTRL_RST  = 8'h06;
    localparam logic [7:0] SCRATCH_RST   = 8'h00;

    localparam int FUNC_RESET_BIT = 5;

    localparam logic [1:0] RXEV_NONE      = 2'b00;
    localparam logic [1:0] RXEV_ACTIVE    = 2'b01;
    localparam logic [1:0] RXEV_HOST_DISC = 2'b10;
    localparam logic [1:0] RXEV_ERROR     = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACK,
        ST_WR_DATA,
        ST_WR_STP,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_RD_BACK,
        ST_RX_TURN,
        ST_RX_DATA,
        ST_RX_BACK
    } phy_state_t;

endpackage

// File: rtl/ulpi_phy_regfile.sv
// ULPI PHY register subset: write/set/clear aliases, read mux and the
// self-clearing Reset bit of Function Control.
module ulpi_phy_regfile
    import ulpi_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic       ulpi_clk,
    input  logic       ulpi_rst_n,
    input  logic [5:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic [7:0] func_ctrl,
    output logic [7:0] intf_ctrl,
    output logic [7:0] otg_ctrl
);

    logic [7:0] scratch;

    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            func_ctrl <= FUNC_CTRL_RST;
            intf_ctrl <= INTF_CTRL_RST;
            otg_ctrl  <= OTG_CTRL_RST;
            scratch   <= SCRATCH_RST;
        end else begin
            // Reset bit drops the cycle after it was committed; a commit in
            // this same cycle overrides it below.
            if (func_ctrl[FUNC_RESET_BIT])
                func_ctrl[FUNC_RESET_BIT] <= 1'b0;
            if (wr_en) begin
                case (addr)
                    REG_FUNC_CTRL:   func_ctrl <= wr_data;
                    REG_FUNC_SET:    func_ctrl <= func_ctrl | wr_data;
                    REG_FUNC_CLR:    func_ctrl <= func_ctrl & ~wr_data;
                    REG_INTF_CTRL:   intf_ctrl <= wr_data;
                    REG_INTF_SET:    intf_ctrl <= intf_ctrl | wr_data;
                    REG_INTF_CLR:    intf_ctrl <= intf_ctrl & ~wr_data;
                    REG_OTG_CTRL:    otg_ctrl  <= wr_data;
                    REG_OTG_SET:     otg_ctrl  <= otg_ctrl | wr_data;
                    REG_OTG_CLR:     otg_ctrl  <= otg_ctrl & ~wr_data;
                    REG_SCRATCH:     scratch   <= wr_data;
                    REG_SCRATCH_SET: scratch   <= scratch | wr_data;
                    REG_SCRATCH_CLR: scratch   <= scratch & ~wr_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            REG_VID_LO: rd_data = VENDOR_ID[7:0];
            REG_VID_HI: rd_data = VENDOR_ID[15:8];
            REG_PID_LO: rd_data = PRODUCT_ID[7:0];
            REG_PID_HI: rd_data = PRODUCT_ID[15:8];
            REG_FUNC_CTRL, REG_FUNC_SET, REG_FUNC_CLR:       rd_data = func_ctrl;
            REG_INTF_CTRL, REG_INTF_SET, REG_INTF_CLR:       rd_data = intf_ctrl;
            REG_OTG_CTRL, REG_OTG_SET, REG_OTG_CLR:          rd_data = otg_ctrl;
            REG_SCRATCH, REG_SCRATCH_SET, REG_SCRATCH_CLR:   rd_data = scratch;
            default: rd_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/ulpi_phy_model.sv
// PHY-side ULPI responder: acknowledges register TX CMDs, turns the bus around
// for reads and emits RX CMDs whenever the modelled line/VBUS/event state moves.
module ulpi_phy_model
    import ulpi_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic       ulpi_clk,
    input  logic       ulpi_rst_n,
    output logic       ulpi_dir,
    output logic       ulpi_nxt,
    input  logic       ulpi_stp,
    input  logic [7:0] ulpi_data_in,
    output logic [7:0] ulpi_data_out,
    input  logic [1:0] line_state_in,
    input  logic [1:0] vbus_state_in,
    input  logic [1:0] rx_event_in,
    output logic [7:0] func_ctrl,
    output logic [7:0] intf_ctrl,
    output logic [7:0] otg_ctrl
);

    phy_state_t state;
    logic [5:0] reg_addr;
    logic       reg_we;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic [5:0] status;
    logic [5:0] last_status;
    logic [5:0] rx_snap;
    logic       wr_commit;

    assign status    = {rx_event_in, vbus_state_in, line_state_in};
    assign wr_commit = (state == ST_WR_STP) && ulpi_stp;

    ulpi_phy_regfile #(
        .VENDOR_ID  (VENDOR_ID),
        .PRODUCT_ID (PRODUCT_ID)
    ) u_regfile (
        .ulpi_clk   (ulpi_clk),
        .ulpi_rst_n (ulpi_rst_n),
        .addr       (reg_addr),
        .wr_en      (wr_commit),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .func_ctrl  (func_ctrl),
        .intf_ctrl  (intf_ctrl),
        .otg_ctrl   (otg_ctrl)
    );

    // Outputs are loaded with the values of the state being entered, so the
    // *_BACK state is the last dir-high cycle and dir falls on return to IDLE.
    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            state         <= ST_IDLE;
            ulpi_dir      <= 1'b0;
            ulpi_nxt      <= 1'b0;
            ulpi_data_out <= 8'h00;
            reg_addr      <= 6'h00;
            reg_we        <= 1'b0;
            wr_data       <= 8'h00;
            last_status   <= 6'h00;
            rx_snap       <= 6'h00;
        end else begin
            ulpi_nxt      <= 1'b0;
            ulpi_data_out <= 8'h00;
            case (state)
                ST_IDLE: begin
                    if (ulpi_data_in[7:6] == CMD_REGW || ulpi_data_in[7:6] == CMD_REGR) begin
                        reg_addr <= ulpi_data_in[5:0];
                        reg_we   <= (ulpi_data_in[7:6] == CMD_REGW);
                        ulpi_nxt <= 1'b1;
                        state    <= ST_ACK;
                    end else if (status != last_status) begin
                        ulpi_dir <= 1'b1;
                        state    <= ST_RX_TURN;
                    end
                end
                ST_ACK: begin
                    if (reg_we) begin
                        ulpi_nxt <= 1'b1;
                        state    <= ST_WR_DATA;
                    end else begin
                        ulpi_dir <= 1'b1;
                        state    <= ST_RD_TURN;
                    end
                end
                ST_WR_DATA: begin
                    wr_data <= ulpi_data_in;
                    state   <= ST_WR_STP;
                end
                ST_WR_STP:  state <= ST_IDLE;
                ST_RD_TURN: begin
                    ulpi_data_out <= rd_data;
                    state         <= ST_RD_DATA;
                end
                ST_RD_DATA: state <= ST_RD_BACK;
                ST_RD_BACK: begin
                    ulpi_dir <= 1'b0;
                    state    <= ST_IDLE;
                end
                // Inputs moving after this snapshot trigger another RX CMD later.
                ST_RX_TURN: begin
                    rx_snap       <= status;
                    ulpi_data_out <= {2'b00, status};
                    state         <= ST_RX_DATA;
                end
                ST_RX_DATA: begin
                    last_status <= rx_snap;
                    state       <= ST_RX_BACK;
                end
                ST_RX_BACK: begin
                    ulpi_dir <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    ulpi_dir <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_phy_model.sv
// Directed bench for ulpi_phy_model: register reads/writes, RX CMDs,
// command-vs-status priority, aborted write and mid-read reset.
module tb_ulpi_phy_model;

    logic       ulpi_clk = 1'b0;
    logic       ulpi_rst_n = 1'b0;
    logic       ulpi_stp = 1'b0;
    logic [7:0] ulpi_data_in = 8'h00;
    logic [1:0] line_state_in = 2'b00;
    logic [1:0] vbus_state_in = 2'b00;
    logic [1:0] rx_event_in = 2'b00;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_out;
    logic [7:0] func_ctrl;
    logic [7:0] intf_ctrl;
    logic [7:0] otg_ctrl;

    int tests = 0;
    int fails = 0;

    ulpi_phy_model dut (
        .ulpi_clk      (ulpi_clk),
        .ulpi_rst_n    (ulpi_rst_n),
        .ulpi_dir      (ulpi_dir),
        .ulpi_nxt      (ulpi_nxt),
        .ulpi_stp      (ulpi_stp),
        .ulpi_data_in  (ulpi_data_in),
        .ulpi_data_out (ulpi_data_out),
        .line_state_in (line_state_in),
        .vbus_state_in (vbus_state_in),
        .rx_event_in   (rx_event_in),
        .func_ctrl     (func_ctrl),
        .intf_ctrl     (intf_ctrl),
        .otg_ctrl      (otg_ctrl)
    );

    always #5 ulpi_clk = ~ulpi_clk;

    task automatic step();
        @(posedge ulpi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle; returns in the first IDLE cycle after the read.
    task automatic reg_read(input logic [5:0] a, input logic [7:0] exp, input string tag);
        int dc;
        int nc;
        logic [7:0] d;
        dc = 0;
        nc = 0;
        d = 8'h00;
        ulpi_data_in = {2'b11, a};
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) ulpi_data_in = 8'h00;
            if (ulpi_dir) dc++;
            if (ulpi_nxt) nc++;
            if (i == 3) d = ulpi_data_out;
        end
        chk({tag, "_data"}, 32'(d), 32'(exp));
        chk({tag, "_dir_cycles"}, 32'(dc), 32'd3);
        chk({tag, "_nxt_cycles"}, 32'(nc), 32'd1);
    endtask

    // Returns in the cycle right after the stp cycle (commit visible there).
    task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input logic s, input string tag);
        int nc;
        int dc;
        nc = 0;
        dc = 0;
        ulpi_data_in = {2'b10, a};
        step();
        ulpi_data_in = d;
        if (ulpi_nxt) nc++;
        if (ulpi_dir) dc++;
        step();
        if (ulpi_nxt) nc++;
        if (ulpi_dir) dc++;
        step();
        if (ulpi_nxt) nc++;
        if (ulpi_dir) dc++;
        ulpi_data_in = 8'h00;
        ulpi_stp = s;
        step();
        ulpi_stp = 1'b0;
        chk({tag, "_nxt_cycles"}, 32'(nc), 32'd2);
        chk({tag, "_dir_cycles"}, 32'(dc), 32'd0);
    endtask

    task automatic watch_rx(input int n, output int dc, output int nc, output logic [7:0] rx_byte);
        dc = 0;
        nc = 0;
        rx_byte = 8'hFF;
        for (int i = 0; i < n; i++) begin
            step();
            if (ulpi_dir) begin
                dc++;
                if (dc == 2) rx_byte = ulpi_data_out;
            end
            if (ulpi_nxt) nc++;
        end
    endtask

    initial begin
        int dc;
        int nc;
        logic [7:0] rxb;

        step();
        step();
        chk("rst_dir", 32'(ulpi_dir), 32'd0);
        chk("rst_nxt", 32'(ulpi_nxt), 32'd0);
        chk("rst_data", 32'(ulpi_data_out), 32'h00);
        chk("rst_func", 32'(func_ctrl), 32'h41);
        chk("rst_intf", 32'(intf_ctrl), 32'h00);
        chk("rst_otg", 32'(otg_ctrl), 32'h06);
        ulpi_rst_n = 1'b1;
        step();

        reg_read(6'h00, 8'h24, "rd_vid_lo");
        reg_read(6'h01, 8'h04, "rd_vid_hi");
        reg_read(6'h02, 8'h09, "rd_pid_lo");
        reg_read(6'h03, 8'h00, "rd_pid_hi");
        reg_read(6'h05, 8'h41, "rd_func_alias");
        reg_read(6'h20, 8'h00, "rd_unmapped");

        reg_write(6'h16, 8'hA5, 1'b1, "wr_scratch");
        reg_write(6'h17, 8'h0A, 1'b1, "set_scratch");
        reg_write(6'h18, 8'h21, 1'b1, "clr_scratch");
        reg_read(6'h16, 8'h8E, "rd_scratch");

        reg_write(6'h04, 8'h61, 1'b1, "wr_func");
        chk("func_commit", 32'(func_ctrl), 32'h61);
        step();
        chk("func_selfclr", 32'(func_ctrl), 32'h41);
        step();

        line_state_in = 2'b01;
        watch_rx(6, dc, nc, rxb);
        chk("rx_line_dir_cycles", 32'(dc), 32'd3);
        chk("rx_line_nxt_cycles", 32'(nc), 32'd0);
        chk("rx_line_byte", 32'(rxb), 32'h01);
        watch_rx(8, dc, nc, rxb);
        chk("rx_stable_dir_cycles", 32'(dc), 32'd0);

        line_state_in = 2'b00;
        watch_rx(6, dc, nc, rxb);
        chk("rx_line0_dir_cycles", 32'(dc), 32'd3);
        chk("rx_line0_byte", 32'(rxb), 32'h00);

        vbus_state_in = 2'b11;
        reg_read(6'h07, 8'h00, "rd_intf_prio");
        watch_rx(6, dc, nc, rxb);
        chk("rx_vbus_dir_cycles", 32'(dc), 32'd3);
        chk("rx_vbus_nxt_cycles", 32'(nc), 32'd0);
        chk("rx_vbus_byte", 32'(rxb), 32'h0C);

        reg_write(6'h0A, 8'hFF, 1'b0, "wr_otg_abort");
        step();
        chk("otg_after_abort", 32'(otg_ctrl), 32'h06);
        reg_write(6'h0B, 8'h80, 1'b1, "set_otg");
        chk("otg_after_set", 32'(otg_ctrl), 32'h86);
        reg_write(6'h07, 8'h5A, 1'b1, "wr_intf");
        chk("intf_after_wr", 32'(intf_ctrl), 32'h5A);

        ulpi_data_in = 8'hD6;
        step();
        ulpi_data_in = 8'h00;
        step();
        step();
        chk("mid_rd_dir", 32'(ulpi_dir), 32'd1);
        chk("mid_rd_data", 32'(ulpi_data_out), 32'h8E);
        #2 ulpi_rst_n = 1'b0;
        #1;
        chk("async_rst_dir", 32'(ulpi_dir), 32'd0);
        chk("async_rst_data", 32'(ulpi_data_out), 32'h00);
        chk("async_rst_func", 32'(func_ctrl), 32'h41);
        chk("async_rst_intf", 32'(intf_ctrl), 32'h00);
        chk("async_rst_otg", 32'(otg_ctrl), 32'h06);
        step();
        ulpi_rst_n = 1'b1;
        vbus_state_in = 2'b00;
        step();
        reg_read(6'h16, 8'h00, "rd_scratch_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
